// File: rtl/router_pkt_scheduler.sv
// Round-robin packet scheduler in front of the router's 1x3 input port.
// Arbitrates N_REQ requesters, emits a header word, streams the granted
// source's payload (padding with zeros on source underrun), then emits the
// parity word. Router busy stalls all non-idle progress.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req[N_REQ]            request level per requester, held until done/rej
//   dest[2*N_REQ]         destination per requester, slice i = [2i+1:2i]
//   len[LEN_W*N_REQ]      payload length per requester (words)
//   src_data, src_valid   payload word from the granted requester
//   src_rd                payload word consumed this cycle (combinational)
//   gnt[N_REQ]            registered one-hot grant
//   done[N_REQ]           one-cycle pulse, packet fully sent
//   rej[N_REQ]            one-cycle pulse, request rejected (dest 3 or len 0)
//   underrun              pulses with done when any zero pad was inserted
//   data_in, pkt_valid    to router
//   busy                  from router
module router_pkt_scheduler #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = DATA_W - 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     dest,
    input  logic [LEN_W*N_REQ-1:0] len,
    input  logic [DATA_W-1:0]      src_data,
    input  logic                   src_valid,
    output logic                   src_rd,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       rej,
    output logic                   underrun,
    output logic [DATA_W-1:0]      data_in,
    output logic                   pkt_valid,
    input  logic                   busy
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HLEN_W = DATA_W - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_PARITY  = 2'd3
    } state_t;

    // Registered state
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  parity_q, parity_d;
    logic               pad_q, pad_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   rej_q, rej_d;
    logic               underrun_q, underrun_d;
    logic [DATA_W-1:0]  data_in_q, data_in_d;
    logic               pkt_valid_q, pkt_valid_d;

    // Per-requester views of the flattened request buses
    logic [1:0]         dest_a [N_REQ];
    logic [LEN_W-1:0]   len_a  [N_REQ];

    // Arbitration result
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic [1:0]         pick_dest;
    logic [LEN_W-1:0]   pick_len;
    logic               pick_bad;
    logic [DATA_W-1:0]  header_c;

    logic               adv_c;
    logic [DATA_W-1:0]  word_c;

    // Index base+step wrapped into 0..N_REQ-1 (both operands already in range)
    function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base,
                                                 input int unsigned      step);
        int unsigned sum;
        sum = 32'(base) + step;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Unpack flattened request fields
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            dest_a[i] = dest[2*i +: 2];
            len_a[i]  = len[LEN_W*i +: LEN_W];
        end
    end

    // Round-robin pick: first active requester at or after rr_ptr, with wrap
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = rr_slot(rr_ptr_q, k);
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    assign pick_dest = dest_a[pick_idx];
    assign pick_len  = len_a[pick_idx];
    assign pick_bad  = (pick_dest == 2'd3) || (pick_len == '0);
    assign header_c  = {pick_len[HLEN_W-1:0], pick_dest};
    assign adv_c     = !busy;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        parity_d    = parity_q;
        pad_d       = pad_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rej_d       = '0;
        underrun_d  = 1'b0;
        data_in_d   = data_in_q;
        pkt_valid_d = pkt_valid_q;
        src_rd      = 1'b0;
        word_c      = '0;

        unique case (state_q)
            S_IDLE: begin
                // Arbitration ignores busy; the header is presented and then held
                if (pick_vld) begin
                    if (pick_bad) begin
                        rej_d    = N_REQ'(1) << pick_idx;
                        rr_ptr_d = rr_slot(pick_idx, 1);
                    end else begin
                        gidx_d      = pick_idx;
                        gnt_d       = N_REQ'(1) << pick_idx;
                        cnt_d       = pick_len;
                        data_in_d   = header_c;
                        parity_d    = header_c;
                        pad_d       = 1'b0;
                        pkt_valid_d = 1'b1;
                        state_d     = S_HEADER;
                    end
                end
            end

            S_HEADER, S_PAYLOAD: begin
                if (adv_c) begin
                    if (cnt_q != '0) begin
                        // Missing source data is replaced by a zero pad word
                        src_rd    = src_valid;
                        word_c    = src_valid ? src_data : '0;
                        data_in_d = word_c;
                        parity_d  = parity_q ^ word_c;
                        cnt_d     = cnt_q - LEN_W'(1);
                        if (!src_valid) begin
                            pad_d = 1'b1;
                        end
                        state_d = S_PAYLOAD;
                    end else begin
                        data_in_d   = parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (adv_c) begin
                    data_in_d  = '0;
                    gnt_d      = '0;
                    done_d     = N_REQ'(1) << gidx_q;
                    underrun_d = pad_q;
                    pad_d      = 1'b0;
                    rr_ptr_d   = rr_slot(gidx_q, 1);
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any packet in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            parity_q    <= '0;
            pad_q       <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            rej_q       <= '0;
            underrun_q  <= 1'b0;
            data_in_q   <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            cnt_q       <= cnt_d;
            parity_q    <= parity_d;
            pad_q       <= pad_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rej_q       <= rej_d;
            underrun_q  <= underrun_d;
            data_in_q   <= data_in_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rej       = rej_q;
    assign underrun  = underrun_q;
    assign data_in   = data_in_q;
    assign pkt_valid = pkt_valid_q;

endmodule

// File: tb/tb_router_pkt_scheduler.sv
// Scoreboard bench for router_pkt_scheduler: a packet-level reference model
// pushes the expected router word stream and completion pulses; a negedge
// monitor pops and compares whenever the router consumes a word or the DUT
// pulses done/rej.
module tb_router_pkt_scheduler;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int LW   = DW - 2;
    localparam int MAXL = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [2*N-1:0]    dest;
    logic [LW*N-1:0]   len;
    logic [DW-1:0]     src_data;
    logic              src_valid;
    logic              src_rd;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [N-1:0]      rej;
    logic              underrun;
    logic [DW-1:0]     data_in;
    logic              pkt_valid;
    logic              busy;

    router_pkt_scheduler #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset), .req(req), .dest(dest), .len(len),
        .src_data(src_data), .src_valid(src_valid), .src_rd(src_rd),
        .gnt(gnt), .done(done), .rej(rej), .underrun(underrun),
        .data_in(data_in), .pkt_valid(pkt_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          pv;
        logic [N-1:0]  oh;
    } word_t;

    typedef struct packed {
        logic [N-1:0] dn;
        logic [N-1:0] rj;
        logic         ur;
    } cmpl_t;

    word_t wq[$];
    cmpl_t cq[$];
    int    checks   = 0;
    int    failures = 0;

    // Request descriptors presented by each requester
    logic [1:0]    r_dest [N];
    logic [LW-1:0] r_len  [N];
    logic [DW-1:0] r_data [N][MAXL];
    logic          r_vld  [N][MAXL];
    int            m_ptr;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest[2*i +: 2]   = r_dest[i];
            len[LW*i +: LW]  = r_len[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: serve a fixed set of pending requests in round-robin order
    function automatic void model_round(input logic [N-1:0] mask);
        logic [N-1:0]  pend;
        logic [N-1:0]  oh;
        logic [DW-1:0] hdr;
        logic [DW-1:0] par;
        logic [DW-1:0] pay;
        logic          ur;
        int            pick;
        pend = mask;
        while (pend != '0) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
            oh    = N'(1) << pick;
            pend  = pend & ~oh;
            m_ptr = (pick + 1) % N;
            if (r_dest[pick] == 2'd3 || r_len[pick] == '0) begin
                cq.push_back('{dn: '0, rj: oh, ur: 1'b0});
            end else begin
                hdr = {r_len[pick], r_dest[pick]};
                par = hdr;
                ur  = 1'b0;
                wq.push_back('{data: hdr, pv: 1'b1, oh: oh});
                for (int s = 0; s < int'(r_len[pick]); s++) begin
                    pay = r_vld[pick][s] ? r_data[pick][s] : '0;
                    if (!r_vld[pick][s]) ur = 1'b1;
                    par = par ^ pay;
                    wq.push_back('{data: pay, pv: 1'b1, oh: oh});
                end
                wq.push_back('{data: par, pv: 1'b0, oh: oh});
                cq.push_back('{dn: oh, rj: '0, ur: ur});
            end
        end
    endfunction

    // Monitor: a word is consumed at the next edge whenever a packet is granted and busy=0
    word_t mon_w;
    cmpl_t mon_c;
    always @(negedge clock) begin
        if (!reset) begin
            if (gnt != '0 && !busy) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got data_in=0x%0h pkt_valid=%0b gnt=%b, expected no word",
                             data_in, pkt_valid, gnt);
                end else begin
                    mon_w = wq.pop_front();
                    check("router_word{data,pv,gnt}", 32'({data_in, pkt_valid, gnt}), 32'(mon_w));
                end
            end
            if ((done | rej) != '0) begin
                if (cq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got done=%b rej=%b, expected none", done, rej);
                end else begin
                    mon_c = cq.pop_front();
                    check("completion{done,rej,underrun}", 32'({done, rej, underrun}), 32'(mon_c));
                end
                check("idle_on_completion{gnt,pv,data}", 32'({gnt, pkt_valid, data_in}), 32'(0));
            end
            check("underrun_only_with_done", 32'(underrun && (done == '0)), 32'(0));
            if (src_rd) begin
                check("src_rd_protocol{busy,nogrant,nopv,noval}",
                      32'({busy, gnt == '0, !pkt_valid, !src_valid}), 32'(0));
            end
        end
    end

    // Driver state
    int   slot;
    logic consumed;
    int   busy_mode;
    int   stall_cnt;
    int   b2_cycles;
    logic chk_gap;
    logic gap_pending;

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock of stimulus: requesters drop on done/rej, source follows its slot plan
    task automatic drive_cycle();
        int g;
        @(posedge clock);
        #1;
        if (gnt == '0) slot = 0;
        else if (consumed) slot++;
        if (chk_gap && gap_pending) check("one_idle_cycle_then_grant", 32'(gnt != '0), 32'(1));
        gap_pending = ((done | rej) != '0) && ((req & ~(done | rej)) != '0);
        req = req & ~(done | rej);
        case (busy_mode)
            1: busy = ($urandom_range(0, 3) == 0);
            2: begin
                busy = 1'b0;
                if (gnt != '0 && data_in == 8'hB2 && stall_cnt < 3) begin
                    busy = 1'b1;
                    stall_cnt++;
                end
            end
            default: busy = 1'b0;
        endcase
        if (gnt != '0 && data_in == 8'hB2) b2_cycles++;
        g = oh2idx(gnt);
        if (gnt != '0 && slot < int'(r_len[g])) begin
            src_valid = r_vld[g][slot];
            src_data  = r_data[g][slot];
        end else begin
            src_valid = 1'($urandom_range(0, 1));
            src_data  = DW'($urandom);
        end
        consumed = (gnt != '0) && pkt_valid && !busy;
    endtask

    task automatic recover();
        reset = 1'b1;
        req   = '0;
        drive_cycle();
        reset = 1'b0;
        wq.delete();
        cq.delete();
        m_ptr = 0;
    endtask

    task automatic run_round(input logic [N-1:0] mask, input int budget);
        int cyc;
        model_round(mask);
        req = mask;
        cyc = 0;
        while (req != '0 && cyc < budget) begin
            drive_cycle();
            cyc++;
        end
        if (req != '0) begin
            checks++;
            failures++;
            $display("FAIL round_timeout: got pending req=%b after %0d cycles, expected none", req, cyc);
            recover();
        end else begin
            cyc = 0;
            while ((wq.size() != 0 || cq.size() != 0) && cyc < 20) begin
                drive_cycle();
                cyc++;
            end
            check("scoreboard_drained", 32'(wq.size() + cq.size()), 32'(0));
        end
        drive_cycle();
    endtask

    task automatic gen_desc(input int i, input bit allow_bad, input int vld_pct);
        r_dest[i] = allow_bad ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        r_len[i]  = allow_bad ? LW'($urandom_range(0, 5)) : LW'($urandom_range(1, 5));
        for (int s = 0; s < MAXL; s++) begin
            r_data[i][s] = DW'($urandom);
            r_vld[i][s]  = ($urandom_range(0, 99) < vld_pct);
        end
    endtask

    task automatic set_abc(input int i);
        gen_desc(i, 1'b0, 100);
        r_dest[i]    = 2'd1;
        r_len[i]     = LW'(3);
        r_data[i][0] = 8'hA1;
        r_data[i][1] = 8'hB2;
        r_data[i][2] = 8'hC3;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset       = 1'b1;
        req         = '0;
        busy        = 1'b0;
        src_valid   = 1'b0;
        src_data    = '0;
        slot        = 0;
        consumed    = 1'b0;
        busy_mode   = 0;
        stall_cnt   = 0;
        b2_cycles   = 0;
        chk_gap     = 1'b0;
        gap_pending = 1'b0;
        m_ptr       = 0;
        for (int i = 0; i < N; i++) gen_desc(i, 1'b0, 100);

        repeat (3) drive_cycle();
        check("reset_outputs", 32'({gnt, done, rej, underrun, data_in, pkt_valid, src_rd}), 32'(0));
        reset = 1'b0;
        drive_cycle();

        // Single packet: 0D A1 B2 C3 DD
        set_abc(0);
        busy_mode = 0;
        run_round(3'b001, 100);

        // Busy stall on B2 for three cycles
        set_abc(0);
        busy_mode = 2;
        stall_cnt = 0;
        b2_cycles = 0;
        run_round(3'b001, 100);
        check("b2_held_cycles", 32'(b2_cycles), 32'(4));

        // Round robin, all len=1, twice so the pointer wraps
        busy_mode = 0;
        chk_gap   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                gen_desc(i, 1'b0, 100);
                r_len[i] = LW'(1);
            end
            run_round(3'b111, 100);
        end
        chk_gap = 1'b0;

        // Rejects: dest 3 and len 0
        gen_desc(1, 1'b0, 100);
        r_dest[1] = 2'd3;
        r_len[1]  = LW'(2);
        gen_desc(2, 1'b0, 100);
        r_dest[2] = 2'd0;
        r_len[2]  = '0;
        busy_mode = 1;
        run_round(3'b110, 100);

        // Underrun: second payload word missing
        gen_desc(0, 1'b0, 100);
        r_dest[0]   = 2'd1;
        r_len[0]    = LW'(2);
        r_vld[0][1] = 1'b0;
        busy_mode   = 0;
        run_round(3'b001, 100);

        // Reset in the middle of a payload
        gen_desc(1, 1'b0, 100);
        r_len[1] = LW'(5);
        model_round(3'b010);
        req = 3'b010;
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            drive_cycle();
            cyc++;
        end
        check("midreset_grant", 32'(gnt), 32'(3'b010));
        drive_cycle();
        reset = 1'b1;
        req   = '0;
        drive_cycle();
        check("midreset_outputs", 32'({gnt, done, rej, underrun, data_in, pkt_valid, src_rd}), 32'(0));
        reset = 1'b0;
        wq.delete();
        cq.delete();
        m_ptr = 0;
        for (int i = 0; i < N; i++) gen_desc(i, 1'b0, 100);
        run_round(3'b111, 200);

        // Randomized rounds
        busy_mode = 1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) gen_desc(i, 1'b1, 85);
            run_round(N'($urandom_range(1, 7)), 400);
        end

        drive_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
